// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- multi-cycle Hack-style instruction sequencer.
//
// Each instruction takes five cycles: FETCH -> LATCH -> WAIT -> EXEC -> WB.
// The sequencer owns PC and IR and runs the ALU. The A, D and M storage lives
// in an external memory controller. This block drives that controller through
// data_out and the three write-enable pulses.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rom_addr  [15:0]  instruction ROM address (= PC)
//   rom_data  [15:0]  instruction word, valid one cycle after rom_addr
//   reg_a_in  [15:0]  current A register
//   reg_d_in  [15:0]  current D register
//   reg_m_in  [15:0]  current RAM[A]
//   reg_a_en          write data_out to A
//   reg_d_en          write data_out to D
//   reg_m_en          write data_out to RAM[A]
//   data_out  [15:0]  value to write
//   pc_out    [15:0]  current PC
//   halted            self-jump halt detected
//
// Optional feature: define CPU_SEQUENCER_HALT_EN to enable halt detection.
// With it enabled, "0;JMP" to its own address stops the sequencer in FETCH
// until reset. Without it, halted is tied low and self-jumps simply loop.
//
// Output timing: every output is registered. Values that are decided in EXEC
// become visible during WB. The deferred C-instruction A write is decided in
// WB and becomes visible in the following FETCH cycle. As a result, an M write
// always uses the old A.

module cpu_sequencer (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic [15:0] reg_a_in,
    input  logic [15:0] reg_d_in,
    input  logic [15:0] reg_m_in,
    output logic        reg_a_en,
    output logic        reg_d_en,
    output logic        reg_m_en,
    output logic [15:0] data_out,
    output logic [15:0] pc_out,
    output logic        halted
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    logic [2:0]  state;
    logic [15:0] pc;
    logic [15:0] ir;

    // C-instruction fields
    logic        is_c;
    logic        f_a, f_zx, f_nx, f_zy, f_ny, f_f, f_no;
    logic        f_da, f_dd, f_dm;
    logic [2:0]  f_j;

    assign is_c = ir[15];
    assign f_a  = ir[12];
    assign f_zx = ir[11];
    assign f_nx = ir[10];
    assign f_zy = ir[9];
    assign f_ny = ir[8];
    assign f_f  = ir[7];
    assign f_no = ir[6];
    assign f_da = ir[5];
    assign f_dd = ir[4];
    assign f_dm = ir[3];
    assign f_j  = ir[2:0];

    // ALU
    logic [15:0] x_op, y_op, alu_raw, alu;
    logic        alu_zr, alu_ng, take_jump;

    always_comb begin
        x_op = reg_d_in;
        y_op = f_a ? reg_m_in : reg_a_in;
        if (f_zx) x_op = 16'h0000;
        if (f_nx) x_op = ~x_op;
        if (f_zy) y_op = 16'h0000;
        if (f_ny) y_op = ~y_op;
        alu_raw = f_f ? (x_op + y_op) : (x_op & y_op);
        alu     = f_no ? ~alu_raw : alu_raw;
    end

    assign alu_zr    = (alu == 16'h0000);
    assign alu_ng    = alu[15];
    assign take_jump = (f_j[2] & alu_ng) | (f_j[1] & alu_zr) | (f_j[0] & ~alu_ng & ~alu_zr);

`ifdef CPU_SEQUENCER_HALT_EN
    logic halt_q;
    logic halt_hit;
    // An unconditional jump to its own address can never make progress.
    assign halt_hit = is_c && (f_j == 3'b111) && (reg_a_in == pc);
    assign halted   = halt_q;
`else
    assign halted   = 1'b0;
`endif

    assign rom_addr = pc;
    assign pc_out   = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= 16'h0000;
            ir       <= 16'h0000;
            data_out <= 16'h0000;
            reg_a_en <= 1'b0;
            reg_d_en <= 1'b0;
            reg_m_en <= 1'b0;
`ifdef CPU_SEQUENCER_HALT_EN
            halt_q   <= 1'b0;
`endif
        end else begin
            // Enables are single-cycle pulses by default.
            reg_a_en <= 1'b0;
            reg_d_en <= 1'b0;
            reg_m_en <= 1'b0;
            case (state)
                S_FETCH: begin
`ifdef CPU_SEQUENCER_HALT_EN
                    if (!halt_q) state <= S_LATCH;
`else
                    state <= S_LATCH;
`endif
                end
                S_LATCH: begin
                    ir    <= rom_data;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // M follows A through a 2-cycle path; let it settle.
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!is_c) begin
                        data_out <= {1'b0, ir[14:0]};
                        reg_a_en <= 1'b1;
                        pc       <= pc + 16'd1;
                    end else begin
                        data_out <= alu;
                        reg_d_en <= f_dd;
                        reg_m_en <= f_dm;
                        pc       <= take_jump ? reg_a_in : pc + 16'd1;
                    end
                    state <= S_WB;
`ifdef CPU_SEQUENCER_HALT_EN
                    // D/M writes of the halting instruction still go out.
                    // Its A write and WB are skipped.
                    if (halt_hit) begin
                        halt_q <= 1'b1;
                        state  <= S_FETCH;
                    end
`endif
                end
                S_WB: begin
                    // The A write is issued one cycle after the M write.
                    // This ensures the M write still uses the old A.
                    reg_a_en <= is_c & f_da;
                    state    <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer -- self-checking bench for cpu_sequencer.
// Provides a registered ROM and an A/D/RAM memory-controller model. It runs a
// program table, checking each instruction's 5-cycle window (LATCH .. next
// FETCH), then runs hand-written halt and reset-abort sequences.

module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rom_addr, rom_data;
    logic [15:0] reg_a_in, reg_d_in, reg_m_in;
    logic        reg_a_en, reg_d_en, reg_m_en;
    logic [15:0] data_out, pc_out;
    logic        halted;

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .reg_a_in (reg_a_in),
        .reg_d_in (reg_d_in),
        .reg_m_in (reg_m_in),
        .reg_a_en (reg_a_en),
        .reg_d_en (reg_d_en),
        .reg_m_en (reg_m_en),
        .data_out (data_out),
        .pc_out   (pc_out),
        .halted   (halted)
    );

    // Environment: registered ROM, A/D registers, small RAM.
    logic [15:0] rom [0:65535];
    logic [15:0] ram [0:255];
    logic [15:0] a_q = 16'h0000;
    logic [15:0] d_q = 16'h0000;
    logic [15:0] rom_q = 16'h0000;

    assign rom_data = rom_q;
    assign reg_a_in = a_q;
    assign reg_d_in = d_q;
    assign reg_m_in = ram[a_q[7:0]];

    always @(posedge clk) begin
        rom_q <= rom[rom_addr];
        if (reg_a_en) a_q <= data_out;
        if (reg_d_en) d_q <= data_out;
        if (reg_m_en) ram[a_q[7:0]] <= data_out;
    end

    // Window bit k corresponds to cycle k+2 of the instruction.
    // Bit 3 is WB; bit 4 is the next FETCH.
    localparam logic [4:0] B3 = 5'b01000;
    localparam logic [4:0] B4 = 5'b10000;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] data;
        logic [4:0]  d;
        logic [4:0]  m;
        logic [4:0]  a;
        logic [15:0] npc;
    } vec_t;

    vec_t tbl [20];
    vec_t hlt [4];
    vec_t sb [$];

    int tests = 0;
    int failed = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst pc_out", pc_out, 16'h0000);
        chk("rst data_out", data_out, 16'h0000);
        chk("rst enables", {13'b0, reg_a_en, reg_d_en, reg_m_en}, 16'h0000);
        chk("rst halted", {15'b0, halted}, 16'h0000);
        chk("rst rom_addr", rom_addr, 16'h0000);
        rst = 1'b0;   // this cycle is the first FETCH
    endtask

    // Sample one instruction window and check it against the next scoreboard entry.
    task automatic run_window(input string tag);
        vec_t e;
        logic [4:0]  dm, mm, am;
        logic [15:0] dv, pv;
        dm = '0; mm = '0; am = '0; dv = '0; pv = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dm[k] = reg_d_en;
            mm[k] = reg_m_en;
            am[k] = reg_a_en;
            if (k == 3) begin
                dv = data_out;
                pv = pc_out;
            end
        end
        if (sb.size() == 0) begin
            tests++; failed++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " data_out"}, dv, e.data);
            chk({tag, " d_en"}, {11'b0, dm}, {11'b0, e.d});
            chk({tag, " m_en"}, {11'b0, mm}, {11'b0, e.m});
            chk({tag, " a_en"}, {11'b0, am}, {11'b0, e.a});
            chk({tag, " pc"}, pv, e.npc);
        end
    endtask

    initial begin
        // pc, instr, data_out@WB, d, m, a windows, PC after EXEC
        tbl[0]  = '{16'h0000, 16'h1234, 16'h1234, 5'b0, 5'b0, B3,   16'h0001};
        tbl[1]  = '{16'h0001, 16'h0005, 16'h0005, 5'b0, 5'b0, B3,   16'h0002};
        tbl[2]  = '{16'h0002, 16'h8C10, 16'h0005, B3,   5'b0, 5'b0, 16'h0003}; // D=A, IR[14:13]=00
        tbl[3]  = '{16'h0003, 16'hE7E8, 16'h0006, 5'b0, B3,   B4,   16'h0004}; // AM=D+1
        tbl[4]  = '{16'h0004, 16'hEE90, 16'hFFFF, B3,   5'b0, 5'b0, 16'h0005}; // D=-1
        tbl[5]  = '{16'h0005, 16'hE7D0, 16'h0000, B3,   5'b0, 5'b0, 16'h0006}; // D=D+1 wraps
        tbl[6]  = '{16'h0006, 16'h0010, 16'h0010, 5'b0, 5'b0, B3,   16'h0007};
        tbl[7]  = '{16'h0007, 16'hE302, 16'h0000, 5'b0, 5'b0, 5'b0, 16'h0010}; // D;JEQ taken
        tbl[8]  = '{16'h0010, 16'hE301, 16'h0000, 5'b0, 5'b0, 5'b0, 16'h0011}; // D;JGT not taken
        tbl[9]  = '{16'h0011, 16'hEFD0, 16'h0001, B3,   5'b0, 5'b0, 16'h0012}; // D=1
        tbl[10] = '{16'h0012, 16'h0020, 16'h0020, 5'b0, 5'b0, B3,   16'h0013};
        tbl[11] = '{16'h0013, 16'hE301, 16'h0001, 5'b0, 5'b0, 5'b0, 16'h0020}; // D;JGT taken
        tbl[12] = '{16'h0020, 16'hE304, 16'h0001, 5'b0, 5'b0, 5'b0, 16'h0021}; // D;JLT not taken
        tbl[13] = '{16'h0021, 16'h0005, 16'h0005, 5'b0, 5'b0, B3,   16'h0022};
        tbl[14] = '{16'h0022, 16'hFC10, 16'h0006, B3,   5'b0, 5'b0, 16'h0023}; // D=M
        tbl[15] = '{16'h0023, 16'hFC98, 16'h0005, B3,   B3,   5'b0, 16'h0024}; // MD=M-1
        tbl[16] = '{16'h0024, 16'hEEA0, 16'hFFFF, 5'b0, 5'b0, B4,   16'h0025}; // A=-1
        tbl[17] = '{16'h0025, 16'hEA87, 16'h0000, 5'b0, 5'b0, 5'b0, 16'hFFFF}; // 0;JMP
        tbl[18] = '{16'hFFFF, 16'hEFD0, 16'h0001, B3,   5'b0, 5'b0, 16'h0000}; // PC wraps
        tbl[19] = '{16'h0000, 16'h1234, 16'h1234, 5'b0, 5'b0, B3,   16'h0001};

        hlt[0]  = '{16'h0000, 16'h0003, 16'h0003, 5'b0, 5'b0, B3,   16'h0001};
        hlt[1]  = '{16'h0001, 16'h0003, 16'h0003, 5'b0, 5'b0, B3,   16'h0002};
        hlt[2]  = '{16'h0002, 16'h0003, 16'h0003, 5'b0, 5'b0, B3,   16'h0003};
        hlt[3]  = '{16'h0003, 16'hEA87, 16'h0000, 5'b0, 5'b0, 5'b0, 16'h0003};

        for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        for (int i = 0; i < 20; i++) rom[tbl[i].pc] = tbl[i].instr;

        // Main program
        do_reset();
        for (int i = 0; i < 20; i++) begin
            sb.push_back(tbl[i]);
            run_window($sformatf("v%0d", i));
        end
        chk("ram[5] after MD=M-1", ram[5], 16'h0005);

        // Self-jump: halt with the feature, endless re-fetch without it
        for (int i = 0; i < 4; i++) rom[hlt[i].pc] = hlt[i].instr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(hlt[i]);
            run_window($sformatf("h%0d", i));
        end
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (rom_addr != 16'h0003 || reg_a_en || reg_d_en || reg_m_en) bad++;
            end
            chk("selfjump bad cycles", bad[15:0], 16'h0000);
`ifdef CPU_SEQUENCER_HALT_EN
            chk("selfjump halted", {15'b0, halted}, 16'h0001);
`else
            chk("selfjump halted", {15'b0, halted}, 16'h0000);
`endif
        end

        // Reset during WB of AM=D+1 drops the deferred A write
        for (int i = 0; i < 4; i++) rom[tbl[i].pc] = tbl[i].instr;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sb.push_back(tbl[i]);
            run_window($sformatf("r%0d", i));
        end
        for (int k = 0; k < 4; k++) @(negedge clk);   // now in WB
        chk("abort m_en in WB", {15'b0, reg_m_en}, 16'h0001);
        chk("abort data_out in WB", data_out, 16'h0006);
        rst = 1'b1;
        @(negedge clk);
        chk("abort a_en", {15'b0, reg_a_en}, 16'h0000);
        chk("abort pc", pc_out, 16'h0000);
        chk("abort A kept", a_q, 16'h0005);
        chk("abort ram[5]", ram[5], 16'h0006);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
